// File: rtl/vc_net_mem_adapter_mo_if.sv
// Handshake bundle between a network terminal, the adapter and a pipelined memory.
// memreq payload is {type, addr, len, data}; memresp payload is {type, len, data}.
interface vc_net_mem_adapter_mo_if #(
    parameter int p_num_nodes = 4,
    parameter int p_addr_sz   = 8,
    parameter int p_data_sz   = 32
);
    localparam int c_sd         = $clog2(p_num_nodes);
    localparam int c_req_sz     = 1 + p_addr_sz + 2 + p_data_sz;
    localparam int c_resp_sz    = 1 + 2 + p_data_sz;
    localparam int c_netreq_sz  = c_req_sz + 2 * c_sd;
    localparam int c_netresp_sz = c_resp_sz + 2 * c_sd;

    logic [c_netreq_sz-1:0]  netout_msg;
    logic                    netout_val;
    logic                    netout_rdy;
    logic [c_req_sz-1:0]     memreq_msg;
    logic                    memreq_val;
    logic                    memreq_rdy;
    logic [c_resp_sz-1:0]    memresp_msg;
    logic                    memresp_val;
    logic                    memresp_rdy;
    logic [c_netresp_sz-1:0] netin_msg;
    logic                    netin_val;
    logic                    netin_rdy;

    // Adapter side
    modport slave (
        input  netout_msg, netout_val,
        output netout_rdy,
        output memreq_msg, memreq_val,
        input  memreq_rdy,
        input  memresp_msg, memresp_val,
        output memresp_rdy,
        output netin_msg, netin_val,
        input  netin_rdy
    );

    // Network/memory environment side
    modport master (
        output netout_msg, netout_val,
        input  netout_rdy,
        input  memreq_msg, memreq_val,
        output memreq_rdy,
        output memresp_msg, memresp_val,
        input  memresp_rdy,
        input  netin_msg, netin_val,
        output netin_rdy
    );
endinterface

// File: rtl/vc_net_mem_adapter_mo.sv
// Network-to-memory adapter with multiple outstanding requests: headers of in-flight
// requests sit in an in-order tag FIFO and are swapped onto the matching responses.
module vc_net_mem_adapter_mo #(
    parameter int p_num_nodes       = 4,
    parameter int p_addr_sz         = 8,
    parameter int p_data_sz         = 32,
    parameter int p_max_outstanding = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    vc_net_mem_adapter_mo_if.slave                 bus,
    output logic [$clog2(p_max_outstanding+1)-1:0] num_inflight,
    output logic                                   err
);
    localparam int c_sd     = $clog2(p_num_nodes);
    localparam int c_req_sz = 1 + p_addr_sz + 2 + p_data_sz;
    localparam int c_tag_sz = 2 * c_sd;
    localparam int c_ptr_w  = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam int c_cnt_w  = $clog2(p_max_outstanding + 1);

    // Each entry holds {orig src, orig dest}, already in outgoing {dest, src} order.
    logic [c_tag_sz-1:0] tag_mem [p_max_outstanding];

    logic [c_ptr_w-1:0] wr_ptr_reg;
    logic [c_ptr_w-1:0] rd_ptr_reg;
    logic [c_cnt_w-1:0] count_reg;
    logic               err_reg;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [c_sd-1:0]    req_dest;
    logic [c_sd-1:0]    req_src;
    logic [c_tag_sz-1:0] head_tag;

    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
        return (ptr == c_ptr_w'(p_max_outstanding - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign req_dest = bus.netout_msg[c_req_sz+c_tag_sz-1 -: c_sd];
    assign req_src  = bus.netout_msg[c_req_sz+c_sd-1 -: c_sd];

    assign full  = (count_reg == c_cnt_w'(p_max_outstanding));
    assign empty = (count_reg == '0);

    // A full FIFO blocks a push even if a pop frees a slot in the same cycle.
    assign bus.memreq_msg = bus.netout_msg[c_req_sz-1:0];
    assign bus.memreq_val = bus.netout_val & ~full;
    assign bus.netout_rdy = bus.memreq_rdy & ~full;
    assign push           = bus.netout_val & bus.netout_rdy;

    // Stray responses (nothing outstanding) are always accepted and dropped.
    assign head_tag        = tag_mem[rd_ptr_reg];
    assign bus.netin_msg   = {head_tag, bus.memresp_msg};
    assign bus.netin_val   = bus.memresp_val & ~empty;
    assign bus.memresp_rdy = bus.netin_rdy | empty;
    assign pop             = bus.memresp_val & bus.netin_rdy & ~empty;

    // Storage is not reset: entries are only read while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_reg] <= {req_src, req_dest};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (bus.memresp_val && empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign num_inflight = count_reg;
    assign err          = err_reg;
endmodule
